// File: rtl/memory_access_arbiter.sv
// memory_access_arbiter: round-robin sharing of one RAM port between instruction fetch and data access.
// Optional MOC timeout abort enabled by defining MEM_TIMEOUT_EN.
module memory_access_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    input  logic              d_req,
    input  logic              d_rw,
    input  logic [1:0]        d_size,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_mov,
    output logic              mem_rw,
    output logic [1:0]        mem_size,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_moc,
    output logic              busy,
    output logic              err
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t state, state_next;
    logic grant_data, last_data, pick_data, grant, timeout;

    // Data wins when alone or when fetch was served last.
    assign pick_data = d_req & (~if_req | ~last_data);
    assign grant     = (state == IDLE) & (if_req | d_req);
    assign mem_mov   = state == WAIT;
    assign busy      = state != IDLE;
    assign if_ack    = (state == RESP) & ~grant_data;
    assign d_ack     = (state == RESP) & grant_data;

`ifdef MEM_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt;
    logic          err_q;
    assign timeout = (state == WAIT) & ~mem_moc & (cnt == CW'(TIMEOUT_CYCLES - 1));
    assign err     = (state == RESP) & err_q;
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt   <= '0;
            err_q <= 1'b0;
        end else begin
            cnt   <= (state != WAIT) ? '0 : (mem_moc ? cnt : cnt + 1'b1);
            err_q <= (state == WAIT) ? timeout : err_q;
        end
    end
`else
    assign timeout = 1'b0;
    assign err     = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = IDLE;
        if (state == IDLE)      state_next = grant ? WAIT : IDLE;
        else if (state == WAIT) state_next = (mem_moc | timeout) ? RESP : WAIT;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            grant_data <= 1'b0;
            last_data  <= 1'b0;
            mem_rw     <= 1'b1;
            mem_size   <= 2'b10;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            rdata      <= '0;
        end else begin
            if (grant) begin
                grant_data <= pick_data;
                last_data  <= pick_data;
                mem_rw     <= pick_data ? d_rw : 1'b1;
                mem_size   <= (pick_data && d_size != 2'b11) ? d_size : 2'b10;
                mem_addr   <= pick_data ? d_addr : if_addr;
                mem_wdata  <= pick_data ? d_wdata : mem_wdata;
            end
            if (state == WAIT && mem_moc && mem_rw) rdata <= mem_rdata;
            else if (timeout)                       rdata <= '0;
        end
    end
endmodule

// File: tb/tb_memory_access_arbiter.sv
// tb_memory_access_arbiter: directed checks of arbitration, handshake timing and reset behaviour.
module tb_memory_access_arbiter;
    logic        clk = 0, reset = 1;
    logic        if_req = 0, d_req = 0, d_rw = 1, mem_moc = 1;
    logic [1:0]  d_size = 2'b10;
    logic [31:0] if_addr = 0, d_addr = 0, d_wdata = 0, mem_rdata = 0;
    logic        if_ack, d_ack, mem_mov, mem_rw, busy, err;
    logic [1:0]  mem_size;
    logic [31:0] rdata, mem_addr, mem_wdata;
    int          errors = 0, checks = 0;

    memory_access_arbiter dut (
        .clk(clk), .reset(reset), .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack),
        .d_req(d_req), .d_rw(d_rw), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .rdata(rdata), .mem_mov(mem_mov), .mem_rw(mem_rw), .mem_size(mem_size),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_moc(mem_moc),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset held two cycles with both requests high
        if_req = 1; d_req = 1;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst_mov", mem_mov, 0);
            chk("rst_ack", {if_ack, d_ack}, 0);
            chk("rst_busy", busy, 0);
            chk("rst_rdata", rdata, 0);
        end
        chk("rst_rw", mem_rw, 1);
        chk("rst_size", mem_size, 2'b10);
        if_req = 0; d_req = 0; reset = 0;
        tick();
        chk("idle_busy", busy, 0);

        // fetch with immediate MOC
        if_req = 1; if_addr = 32'h04; mem_rdata = 32'hE2001028;
        tick();
        chk("f_mov", mem_mov, 1);
        chk("f_addr", mem_addr, 32'h04);
        chk("f_rw", mem_rw, 1);
        chk("f_size", mem_size, 2'b10);
        chk("f_noack", if_ack, 0);
        tick();
        chk("f_ack", {if_ack, d_ack}, 2'b10);
        chk("f_rdata", rdata, 32'hE2001028);
        chk("f_movoff", mem_mov, 0);
        if_req = 0;
        tick();
        chk("f_idle", busy, 0);

        // STRB write leaves rdata alone
        d_req = 1; d_rw = 0; d_size = 2'b00; d_addr = 32'h11; d_wdata = 32'hAB; mem_rdata = 32'h12345678;
        tick();
        chk("s_mov", mem_mov, 1);
        chk("s_size", mem_size, 2'b00);
        chk("s_wdata", mem_wdata, 32'hAB);
        chk("s_rw", mem_rw, 0);
        chk("s_addr", mem_addr, 32'h11);
        tick();
        chk("s_ack", {if_ack, d_ack}, 2'b01);
        chk("s_rdata", rdata, 32'hE2001028);
        d_req = 0;
        tick();

        // request withdrawn early still completes; size 11 becomes word
        d_req = 1; d_rw = 1; d_size = 2'b11; d_addr = 32'h22; mem_rdata = 32'h5A5A0001;
        tick();
        d_req = 0;
        chk("e_size", mem_size, 2'b10);
        chk("e_mov", mem_mov, 1);
        tick();
        chk("e_ack", d_ack, 1);
        chk("e_rdata", rdata, 32'h5A5A0001);
        tick();
        chk("e_idle", busy, 0);

        // contention from reset: D,F,D,F
        reset = 1; tick(); reset = 0;
        if_req = 1; d_req = 1; if_addr = 32'h100; d_addr = 32'h200;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("c_addr", mem_addr, (i % 2 == 0) ? 32'h200 : 32'h100);
            tick();
            chk("c_ack", {if_ack, d_ack}, (i % 2 == 0) ? 2'b01 : 2'b10);
            if (i == 3) begin if_req = 0; d_req = 0; end
            tick();
        end
        chk("c_idle", busy, 0);

        // slow memory: MOC low for five WAIT cycles
        mem_moc = 0; if_req = 1; if_addr = 32'h40; mem_rdata = 32'hCAFEF00D;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("w_mov", mem_mov, 1);
            chk("w_noack", if_ack, 0);
        end
        tick();
        mem_moc = 1;
        chk("w_mov6", mem_mov, 1);
        tick();
        chk("w_ack", if_ack, 1);
        chk("w_rdata", rdata, 32'hCAFEF00D);
        chk("w_err", err, 0);
        if_req = 0;
        tick();

`ifdef MEM_TIMEOUT_EN
        mem_moc = 0; if_req = 1;
        for (int k = 0; k < 16; k++) begin
            tick();
            chk("t_mov", mem_mov, 1);
        end
        tick();
        chk("t_ack", if_ack, 1);
        chk("t_err", err, 1);
        chk("t_rdata", rdata, 0);
        if_req = 0;
        tick();
        if_req = 1;
        for (int k = 0; k < 3; k++) tick();
        reset = 1; if_req = 0;
        tick();
        chk("t_rst_busy", busy, 0);
        chk("t_rst_mov", mem_mov, 0);
        chk("t_rst_ack", {if_ack, d_ack, err}, 0);
        reset = 0;
        mem_moc = 1;
        tick();
`endif

        // reset mid-access abandons it
        if_req = 1; mem_moc = 0;
        tick();
        tick();
        reset = 1; if_req = 0;
        tick();
        chk("r_busy", busy, 0);
        chk("r_mov", mem_mov, 0);
        chk("r_rdata", rdata, 0);
        reset = 0; mem_moc = 1;
        tick();
        chk("r_noack", {if_ack, d_ack}, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
